// File: rtl/tomasulo_cdb_sch.sv
// rtl/tomasulo_cdb_sch.sv - round-robin CDB scheduler with write-back reservation vector
//
// Purpose:
//   Grants at most one reservation-station CDB request per cycle, round-robin,
//   and tracks future CDB write-back slots in a shift-register reservation
//   vector that is broadcast back to the stations.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   req      in   [REQ_N]       per-station CDB request
//   req_lat  in   [REQ_N*LAT_W] execution latency of station i at [i*LAT_W +: LAT_W]
//   gnt      out  [REQ_N]       one-hot0 grant, combinational
//   sch_r    out  [SCH_N]       reservation vector; bit k = CDB reserved k cycles from now
//   cdb_vld  in   observed CDB valid (checker only)
//   err_r    out  sticky checker error
//
// Optional feature macro: TOMASULO_CDB_SCH_CHECK_EN (enables the cdb_vld/sch_r[0] checker)

module tomasulo_cdb_sch #(
  parameter int REQ_N = 4,
  parameter int SCH_N = 8,
  parameter int LAT_W = $clog2(SCH_N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_N-1:0]         req,
  input  logic [REQ_N*LAT_W-1:0]   req_lat,
  output logic [REQ_N-1:0]         gnt,
  output logic [SCH_N-1:0]         sch_r,
  input  logic                     cdb_vld,
  output logic                     err_r
);

  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  logic [SCH_N-1:0] sch_q, sch_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [LAT_W-1:0] lat [REQ_N];
  logic [REQ_N-1:0] elig;

  logic             found;
  logic [PTR_W-1:0] gidx;
  logic [LAT_W-1:0] lat_g;

  // Latency 0 is illegal; an already-reserved slot is masked even though
  // the stations gate on the same bit.
  for (genvar i = 0; i < REQ_N; i++) begin : g_elig
    assign lat[i]  = req_lat[i*LAT_W +: LAT_W];
    assign elig[i] = req[i] & (lat[i] != '0) & ~sch_q[lat[i]];
  end

  // Round-robin search starting one past the last granted index.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= REQ_N; k++) begin
      automatic int idx = (int'(ptr_q) + k) % REQ_N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) begin
      gnt[gidx] = 1'b1;
    end
  end

  assign lat_g = lat[gidx];

  // A grant with latency L lands in sch_r[L-1] next cycle, i.e. sch_r[0]
  // exactly L cycles after the grant.
  always_comb begin
    sch_d = sch_q >> 1;
    ptr_d = ptr_q;
    if (found) begin
      sch_d = sch_d | (SCH_N'(1) << (lat_g - LAT_W'(1)));
      ptr_d = gidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sch_q <= '0;
      ptr_q <= PTR_W'(REQ_N - 1);
    end else begin
      sch_q <= sch_d;
      ptr_q <= ptr_d;
    end
  end

  assign sch_r = sch_q;

`ifdef TOMASULO_CDB_SCH_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (cdb_vld != sch_q[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0(gnt))
        else $error("tomasulo_cdb_sch: gnt not one-hot0: %b", gnt);
    end
  end

  assign err_r = err_q;
`else
  logic unused_cdb_vld;
  assign unused_cdb_vld = cdb_vld;
  assign err_r = 1'b0;
`endif

endmodule

// File: tb/tb_tomasulo_cdb_sch.sv
// tb/tb_tomasulo_cdb_sch.sv - directed self-checking bench for tomasulo_cdb_sch

module tb_tomasulo_cdb_sch;

  localparam int REQ_N = 4;
  localparam int SCH_N = 8;
  localparam int LAT_W = 3;

`ifdef TOMASULO_CDB_SCH_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                   clk;
  logic                   rst_n;
  logic [REQ_N-1:0]       req;
  logic [REQ_N*LAT_W-1:0] req_lat;
  logic [REQ_N-1:0]       gnt;
  logic [SCH_N-1:0]       sch_r;
  logic                   cdb_vld;
  logic                   err_r;
  logic                   cdb_flip;

  int n_chk;
  int n_bad;

  tomasulo_cdb_sch #(.REQ_N(REQ_N), .SCH_N(SCH_N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_lat (req_lat),
    .gnt     (gnt),
    .sch_r   (sch_r),
    .cdb_vld (cdb_vld),
    .err_r   (err_r)
  );

  // A well-behaved CDB follows the reservation; cdb_flip injects a mismatch.
  assign cdb_vld = sch_r[0] ^ cdb_flip;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    req_lat = {LAT_W'(l3), LAT_W'(l2), LAT_W'(l1), LAT_W'(l0)};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_gnt [5];
  logic [7:0] rr_sch [5];

  initial begin
    n_chk    = 0;
    n_bad    = 0;
    cdb_flip = 1'b0;
    rst_n    = 1'b0;
    req      = 4'b1111;
    set_lat(2, 2, 2, 2);

    // Reset held two cycles with all requests pending.
    tick();
    tick();
    sample();
    chk("rst_sch", 32'(sch_r), 32'h00);
    chk("rst_err", 32'(err_r), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    tick();
    sample();
    chk("rst_first_sch", 32'(sch_r), 32'h02);

    // Round-robin with latencies 1..4: the 5th cycle masks requester 0
    // because slot 1 holds requester 2's write-back, so requester 1 wins.
    do_reset();
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
    rr_sch = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0a};
    req = 4'b1111;
    set_lat(1, 2, 3, 4);
    for (int c = 0; c < 5; c++) begin
      sample();
      chk($sformatf("rr_sch%0d", c), 32'(sch_r), 32'(rr_sch[c]));
      chk($sformatf("rr_gnt%0d", c), 32'(gnt), 32'(rr_gnt[c]));
      tick();
    end
    req = '0;
    sample();
    chk("rr_sch_end", 32'(sch_r), 32'h07);

    // Slot collision: req0 L=3 at t, req1 L=2 masked at t+1, granted at t+2.
    do_reset();
    req = 4'b0001;
    set_lat(3, 2, 0, 0);
    sample();
    chk("col_t_gnt", 32'(gnt), 32'h1);
    tick();
    req = 4'b0010;
    sample();
    chk("col_t1_sch", 32'(sch_r), 32'h04);
    chk("col_t1_gnt", 32'(gnt), 32'h0);
    tick();
    sample();
    chk("col_t2_sch", 32'(sch_r), 32'h02);
    chk("col_t2_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0;
    sample();
    chk("col_t3_sch", 32'(sch_r), 32'h03);
    tick();
    sample();
    chk("col_t4_sch", 32'(sch_r), 32'h01);

    // Latency 0 is never granted.
    do_reset();
    req = 4'b0001;
    set_lat(0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      sample();
      chk($sformatf("lat0_gnt%0d", c), 32'(gnt), 32'h0);
      chk($sformatf("lat0_sch%0d", c), 32'(sch_r), 32'h00);
      tick();
    end

    // Maximum latency SCH_N-1.
    do_reset();
    req = 4'b0001;
    set_lat(7, 0, 0, 0);
    sample();
    chk("lat7_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    sample();
    chk("lat7_sch1", 32'(sch_r), 32'h40);
    for (int c = 0; c < 6; c++) tick();
    sample();
    chk("lat7_sch7", 32'(sch_r), 32'h01);
    tick();
    sample();
    chk("lat7_sch8", 32'(sch_r), 32'h00);
    chk("no_err_clean", 32'(err_r), 32'h0);

    // Checker: inject cdb_vld while sch_r[0]=0.
    do_reset();
    cdb_flip = 1'b1;
    tick();
    cdb_flip = 1'b0;
    sample();
    chk("chk_err_set", 32'(err_r), 32'(EXP_ERR));
    tick();
    tick();
    sample();
    chk("chk_err_held", 32'(err_r), 32'(EXP_ERR));
    rst_n = 1'b0;
    tick();
    sample();
    chk("chk_err_rst", 32'(err_r), 32'h0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
